// File: rtl/tryx_pkg.sv
// Shared definitions for the try-x AXI response tracker.
// Optional feature macro: TRYX_RESP_DECERR_EN (treat DECERR as an error too).
package tryx_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RespOkay   = 2'b00;
  localparam axi_resp_t RespExOkay = 2'b01;
  localparam axi_resp_t RespSlvErr = 2'b10;
  localparam axi_resp_t RespDecErr = 2'b11;

  // Extract the core-index field from an AXI ID (ID zero-extended to 32 bits).
  function automatic int unsigned id_to_core(input logic [31:0] id,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (id >> lsb) & mask;
  endfunction

  // Error classification of an AXI response code.
  function automatic logic is_err(input axi_resp_t resp);
`ifdef TRYX_RESP_DECERR_EN
    return resp[1];
`else
    return resp == RespSlvErr;
`endif
  endfunction

endpackage

// File: rtl/tryx_outst_cnt.sv
// Saturating outstanding-transaction counter with overflow/underflow pulses.
// A simultaneous increment and decrement leaves the count unchanged and flags nothing.
module tryx_outst_cnt #(
  parameter int unsigned MaxCount = 8,
  parameter int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic dec_i,
  output logic nonzero_o,
  output logic overflow_o,
  output logic underflow_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count with saturation at MaxCount and floor at zero.
  always_comb begin
    cnt_d       = cnt_q;
    overflow_o  = 1'b0;
    underflow_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CntW'(MaxCount)) overflow_o = 1'b1;
        else                          cnt_d = cnt_q + CntW'(1);
      end
      2'b01: begin
        if (cnt_q == '0) underflow_o = 1'b1;
        else             cnt_d = cnt_q - CntW'(1);
      end
      default: ;
    endcase
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/tryx_resp_tracker.sv
// Passive AXI response monitor: maps B responses and completed R bursts back to the
// issuing core by AXI ID, pulses a per-core completion with error flag, tracks
// outstanding transactions and flags overflow / unexpected responses.
// Optional feature macro: TRYX_RESP_DECERR_EN (DECERR also reported as error).
module tryx_resp_tracker
  import tryx_pkg::*;
#(
  parameter int unsigned NB_CORES        = 4,
  parameter int unsigned AXI_ID_WIDTH    = 6,
  parameter int unsigned CORE_ID_LSB     = 0,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    aw_valid_i,
  input  logic                    aw_ready_i,
  input  logic [AXI_ID_WIDTH-1:0] aw_id_i,
  input  logic                    ar_valid_i,
  input  logic                    ar_ready_i,
  input  logic [AXI_ID_WIDTH-1:0] ar_id_i,
  input  logic                    b_valid_i,
  input  logic                    b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0] b_id_i,
  input  logic [1:0]              b_resp_i,
  input  logic                    r_valid_i,
  input  logic                    r_ready_i,
  input  logic                    r_last_i,
  input  logic [AXI_ID_WIDTH-1:0] r_id_i,
  input  logic [1:0]              r_resp_i,
  output logic [NB_CORES-1:0]     axi_xresp_valid_o,
  output logic [NB_CORES-1:0]     axi_xresp_slverr_o,
  output logic [NB_CORES-1:0]     busy_o,
  output logic [NB_CORES-1:0]     overflow_o,
  output logic [NB_CORES-1:0]     unexpected_o,
  input  logic [NB_CORES-1:0]     clr_flags_i
);

  localparam int unsigned CntW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CoreW = $clog2(NB_CORES);

  logic aw_fire, ar_fire, b_fire, r_fire;
  logic b_err, r_err;
  int unsigned aw_core, ar_core, b_core, r_core;

  logic [NB_CORES-1:0] aw_hit, ar_hit, b_hit, r_hit, r_last_hit;
  logic [NB_CORES-1:0] wr_nz, rd_nz, wr_ovf, rd_ovf, wr_unf, rd_unf;
  logic [NB_CORES-1:0] cmpl_valid, cmpl_err;
  logic [NB_CORES-1:0] rd_acc_q, rd_acc_d;
  logic [NB_CORES-1:0] xvalid_q, xerr_q;
  logic [NB_CORES-1:0] overflow_q, overflow_d;
  logic [NB_CORES-1:0] unexpected_q, unexpected_d;

  assign aw_fire = aw_valid_i & aw_ready_i;
  assign ar_fire = ar_valid_i & ar_ready_i;
  assign b_fire  = b_valid_i & b_ready_i;
  assign r_fire  = r_valid_i & r_ready_i;

  assign aw_core = id_to_core(32'(aw_id_i), CORE_ID_LSB, CoreW);
  assign ar_core = id_to_core(32'(ar_id_i), CORE_ID_LSB, CoreW);
  assign b_core  = id_to_core(32'(b_id_i), CORE_ID_LSB, CoreW);
  assign r_core  = id_to_core(32'(r_id_i), CORE_ID_LSB, CoreW);

  assign b_err = is_err(b_resp_i);
  assign r_err = is_err(r_resp_i);

  // Decode handshakes to per-core hits; out-of-range core indices match no core.
  always_comb begin
    aw_hit     = '0;
    ar_hit     = '0;
    b_hit      = '0;
    r_hit      = '0;
    r_last_hit = '0;
    for (int unsigned c = 0; c < NB_CORES; c++) begin
      aw_hit[c]     = aw_fire & (aw_core == c);
      ar_hit[c]     = ar_fire & (ar_core == c);
      b_hit[c]      = b_fire & (b_core == c);
      r_hit[c]      = r_fire & (r_core == c);
      r_last_hit[c] = r_hit[c] & r_last_i;
    end
  end

  // Read error accumulation and merged B / R-last completion per core.
  always_comb begin
    rd_acc_d   = rd_acc_q;
    cmpl_valid = b_hit | r_last_hit;
    cmpl_err   = '0;
    for (int unsigned c = 0; c < NB_CORES; c++) begin
      if (r_hit[c]) rd_acc_d[c] = r_last_i ? 1'b0 : (rd_acc_q[c] | r_err);
      cmpl_err[c] = (b_hit[c] & b_err) | (r_last_hit[c] & (rd_acc_q[c] | r_err));
    end
  end

  // Sticky flags; a new event in the same cycle as a clear wins.
  always_comb begin
    overflow_d   = (wr_ovf | rd_ovf) | (overflow_q & ~clr_flags_i);
    unexpected_d = (wr_unf | rd_unf) | (unexpected_q & ~clr_flags_i);
  end

  for (genvar c = 0; c < NB_CORES; c++) begin : g_core
    tryx_outst_cnt #(
      .MaxCount(MAX_OUTSTANDING),
      .CntW    (CntW)
    ) u_wr_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (aw_hit[c]),
      .dec_i      (b_hit[c]),
      .nonzero_o  (wr_nz[c]),
      .overflow_o (wr_ovf[c]),
      .underflow_o(wr_unf[c])
    );

    tryx_outst_cnt #(
      .MaxCount(MAX_OUTSTANDING),
      .CntW    (CntW)
    ) u_rd_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (ar_hit[c]),
      .dec_i      (r_last_hit[c]),
      .nonzero_o  (rd_nz[c]),
      .overflow_o (rd_ovf[c]),
      .underflow_o(rd_unf[c])
    );
  end

  // State registers: accumulators, completion pulse, sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_acc_q     <= '0;
      xvalid_q     <= '0;
      xerr_q       <= '0;
      overflow_q   <= '0;
      unexpected_q <= '0;
    end else begin
      rd_acc_q     <= rd_acc_d;
      xvalid_q     <= cmpl_valid;
      xerr_q       <= cmpl_err;
      overflow_q   <= overflow_d;
      unexpected_q <= unexpected_d;
    end
  end

  assign axi_xresp_valid_o  = xvalid_q;
  assign axi_xresp_slverr_o = xerr_q;
  assign busy_o             = wr_nz | rd_nz;
  assign overflow_o         = overflow_q;
  assign unexpected_o       = unexpected_q;

endmodule

// File: doc/tryx_resp_tracker.md
# tryx_resp_tracker

Passive AXI response monitor on the cluster's external AXI master port, upstream of the per-core try-x control registers. It watches the AW/AR/B/R handshakes and uses the AXI ID to map each write response and each completed read burst back to the issuing core. For that core it produces a one-cycle `axi_xresp_valid` pulse with the error flag. It also tracks per-core outstanding transactions and flags protocol anomalies (counter overflow, unexpected response).

## Interface
- `NB_CORES`, 4, number of cores; ports are indexed by core.
- `AXI_ID_WIDTH`, 6, AXI ID width.
- `CORE_ID_LSB`, 0, LSB of the core-index field inside the AXI ID; the field is `$clog2(NB_CORES)` bits wide.
- `MAX_OUTSTANDING`, 8, maximum outstanding transactions per core per direction.
- Clock and reset: one clock; reset is asynchronous and active-low, ports `clk_i` and `rst_ni`.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `aw_valid_i`, `aw_ready_i`  in  1  AW handshake.
- `aw_id_i`  in  `AXI_ID_WIDTH`  AW ID.
- `ar_valid_i`, `ar_ready_i`  in  1  AR handshake.
- `ar_id_i`  in  `AXI_ID_WIDTH`  AR ID.
- `b_valid_i`, `b_ready_i`  in  1  B handshake.
- `b_id_i`  in  `AXI_ID_WIDTH`  B ID.
- `b_resp_i`  in  2  B response code.
- `r_valid_i`, `r_ready_i`, `r_last_i`  in  1  R handshake and last-beat flag.
- `r_id_i`  in  `AXI_ID_WIDTH`  R ID.
- `r_resp_i`  in  2  R response code.
- `axi_xresp_valid_o`  out  `NB_CORES`  per-core completion pulse.
- `axi_xresp_slverr_o`  out  `NB_CORES`  per-core error flag; meaningful only while valid is high.
- `busy_o`  out  `NB_CORES`  core has an outstanding read or write.
- `overflow_o`  out  `NB_CORES`  sticky: a request arrived with the counter at `MAX_OUTSTANDING`.
- `unexpected_o`  out  `NB_CORES`  sticky: a response arrived with the counter at 0.
- `clr_flags_i`  in  `NB_CORES`  clears the sticky flags of the selected cores.

## Operation
- **Handshake.** A channel event fires only when valid and ready are both high in the same cycle. The block is passive and never drives ready.
- **Core index.** Core = `id[CORE_ID_LSB +: $clog2(NB_CORES)]`.
  - If the index is ≥ `NB_CORES`, the event is dropped and no counter changes.
- **Error classification.** An `*_resp` is an error if it equals `2'b10` (SLVERR). DECERR handling is set under Configuration.
- **Write path.**
  - An AW event increments `wr_cnt[c]`.
  - A B event decrements `wr_cnt[c]` and raises a completion for core c with err = error(`b_resp_i`).
- **Read path.**
  - An AR event increments `rd_cnt[c]`.
  - Each R beat ORs error(`r_resp_i`) into `rd_acc[c]`.
  - On the beat with `r_last_i`: decrement `rd_cnt[c]`, raise a completion with err = `rd_acc[c]` | error of this beat, and clear `rd_acc[c]`.
  - Interleaved bursts from different cores accumulate independently.
- **Simultaneous completions.** If B and the R last beat complete for the same core in the same cycle, a single pulse is emitted with err = OR of both, and both counters decrement.
- **Counters.**
  - Width is `$clog2(MAX_OUTSTANDING+1)`.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - An increment at `MAX_OUTSTANDING` saturates and sets `overflow_o[c]`.
  - A decrement at 0 holds 0 and sets `unexpected_o[c]`; the completion pulse is still emitted.
- **Busy.** `busy_o[c]` = (`wr_cnt[c]` != 0) | (`rd_cnt[c]` != 0), from registered counters.
- **Sticky flags.** When a set and `clr_flags_i` hit the same cycle, set wins.

## Timing
- `axi_xresp_valid_o` and `axi_xresp_slverr_o` are registered and assert exactly one cycle after the completing handshake, for one cycle.
- Back-to-back completions produce back-to-back pulses with no bubbles.
- Counters, `rd_acc`, and flags update on the clock edge following the handshake.
- Reset values: all outputs 0, all counters 0, all accumulators 0.
- Reset mid-burst discards the accumulator; a subsequent R last beat then counts as unexpected.

## Configuration
- Macro: `TRYX_RESP_DECERR_EN`.
- Defined: DECERR (`2'b11`) is also an error; `slverr` = `resp[1]`.
- Undefined: only SLVERR (`2'b10`) is an error; DECERR reports err = 0.

## Structure
- `tryx_pkg` holds:
  - the response encodings as `localparam`s (OKAY, EXOKAY, SLVERR, DECERR);
  - the function `id_to_core`;
  - the function `is_err`, which honours the macro.
- `tryx_outst_cnt` is one sub-module: a saturating up/down counter with overflow/underflow flags. It is instantiated `2*NB_CORES` times (read and write per core).

## Test plan
- AW ID 0x01, then B ID 0x01 with resp `2'b10` → cycle after B: `valid_o[1]`=1, `slverr_o[1]`=1; `busy_o[1]` falls.
- AR ID 0x02, then 4-beat R with beat 2 = SLVERR and the others OKAY → single pulse on core 2 after the last beat, err=1; a following clean burst gives err=0.
- Same-cycle B (core 3, OKAY) and R last (core 3, SLVERR) → one pulse, err=1; both counters decrement to 0.
- 9 AWs for core 0 with no B (`MAX_OUTSTANDING`=8) → counter stays 8 and `overflow_o[0]`=1; `clr_flags_i[0]` clears it.
- B for core 1 with no outstanding AW → `unexpected_o[1]`=1 and pulse emitted. Then `b_resp`=`2'b11`: err=1 with the macro defined, err=0 without it.
- Assert `rst_ni` low mid-burst (after 2 of 4 beats) → all outputs 0 during reset; the remaining beats give no error carry-over, and the last beat sets `unexpected_o`.
